// File: rtl/flash_word_fetch_if.sv
// ---------------------------------------------------------------------------
// flash_word_fetch_if
//   CPU-side ROM fetch bus between a CPU core and flash_word_fetch.
//
//   req   CPU -> fetcher   fetch request. It is a level, and addr must stay
//                          stable while req is high and rdy is low.
//   addr  CPU -> fetcher   word address (ADDR_W bits).
//   rdy   fetcher -> CPU   the assembled word is valid. It stays high until
//                          req drops.
//   data  fetcher -> CPU   assembled word (DATA_W bits), byte 0 in [7:0].
//
//   master modport: CPU core.   slave modport: fetcher.
// ---------------------------------------------------------------------------
interface flash_word_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              rdy;
    logic [DATA_W-1:0] data;

    modport master (output req, output addr, input rdy, input data);
    modport slave  (input req, input addr, output rdy, output data);
endinterface

// File: rtl/flash_word_fetch.sv
// ---------------------------------------------------------------------------
// flash_word_fetch
//   Builds a BYTES-wide ROM word from a byte-wide parallel NOR flash. Each
//   byte lane has its own programmable access time of WAIT clock cycles.
//   Lane j of word addr is read from flash byte address
//   (BASE + addr*BYTES + j) mod 2^FL_ADDR_W.
//
//   Optional feature (macro FETCH_PREFETCH_EN):
//     Adds a one-entry last-word buffer and a one-entry sequential prefetch
//     buffer. After a request is released, word addr+1 is fetched in the
//     background (state PREF). A request that hits a buffer is answered
//     without any flash access. A request for the word that is already being
//     prefetched is promoted to a demand fetch. Any other request aborts the
//     prefetch.
//     If the macro is not defined there are no buffers, and every request
//     is a full demand fetch.
//
// Ports
//   CLOCK_50  in   clock; all state changes happen on its rising edge
//   reset_n   in   synchronous, active-low reset
//   bus       slave modport of flash_word_fetch_if (req/addr/rdy/data)
//   busy      out  a flash access is in progress (demand or prefetch)
//   fl_addr   out  flash byte address; holds its value between fetches
//   fl_dq     in   flash data byte
//   fl_ce_n   out  flash chip enable, low while busy
//   fl_oe_n   out  flash output enable, low while busy
// ---------------------------------------------------------------------------
module flash_word_fetch #(
    parameter int                   ADDR_W    = 16,
    parameter int                   BYTES     = 2,
    parameter int                   WAIT      = 4,
    parameter int                   FL_ADDR_W = 22,
    parameter logic [FL_ADDR_W-1:0] BASE      = '0
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    flash_word_fetch_if.slave    bus,
    output logic                 busy,
    output logic [FL_ADDR_W-1:0] fl_addr,
    input  logic [7:0]           fl_dq,
    output logic                 fl_ce_n,
    output logic                 fl_oe_n
);
    localparam int DATA_W = 8 * BYTES;
    localparam int LANE_W = 2;
    localparam int CNT_W  = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

`ifdef FETCH_PREFETCH_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE, S_PREF} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;
`endif

    // Flash byte address of lane 0. The product is kept at FL_ADDR_W bits,
    // so the address wraps modulo the flash size.
    function automatic logic [FL_ADDR_W-1:0] lane0_addr(input logic [ADDR_W-1:0] a);
        logic [FL_ADDR_W-1:0] wa;
        wa = FL_ADDR_W'(a);
        return BASE + wa * FL_ADDR_W'(BYTES);
    endfunction

    state_t                 state_reg, state_next;
    logic [LANE_W-1:0]      lane_reg, lane_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [FL_ADDR_W-1:0]   fl_addr_reg, fl_addr_next;
    logic [DATA_W-1:0]      asm_reg, asm_next;
    logic [DATA_W-1:0]      data_reg, data_next;
    logic                   rdy_reg, rdy_next;

    logic [DATA_W-1:0]      word_cap;
    logic                   cap_now;
    logic                   last_cap;
    logic                   demand_done;
    logic                   start_req;

`ifdef FETCH_PREFETCH_EN
    logic [ADDR_W-1:0]      cur_reg, cur_next;
    logic                   lw_valid_reg, lw_valid_next;
    logic [ADDR_W-1:0]      lw_addr_reg, lw_addr_next;
    logic [DATA_W-1:0]      lw_data_reg, lw_data_next;
    logic                   pf_valid_reg, pf_valid_next;
    logic [ADDR_W-1:0]      pf_addr_reg, pf_addr_next;
    logic [DATA_W-1:0]      pf_data_reg, pf_data_next;
    logic [ADDR_W-1:0]      pref_addr;
    logic                   pf_hit;
    logic                   lw_hit;
    logic                   hit_pf;
    logic                   hit_lw;
    logic                   start_pref;

    assign pref_addr = cur_reg + ADDR_W'(1);
    assign pf_hit    = pf_valid_reg && (pf_addr_reg == bus.addr);
    assign lw_hit    = lw_valid_reg && (lw_addr_reg == bus.addr);
    assign busy      = (state_reg == S_FETCH) || (state_reg == S_PREF);
`else
    assign busy      = (state_reg == S_FETCH);
`endif

    // The word as it will look once fl_dq is captured into the current lane.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        assign word_cap[8*gi +: 8] = (lane_reg == LANE_W'(gi)) ? fl_dq : asm_reg[8*gi +: 8];
    end

    assign cap_now  = (cnt_reg == '0);
    assign last_cap = busy && cap_now && (lane_reg == LAST_LANE);

    always_comb begin
        state_next   = state_reg;
        lane_next    = lane_reg;
        cnt_next     = cnt_reg;
        fl_addr_next = fl_addr_reg;
        asm_next     = asm_reg;
        data_next    = data_reg;
        rdy_next     = rdy_reg;
        demand_done  = 1'b0;
        start_req    = 1'b0;
`ifdef FETCH_PREFETCH_EN
        cur_next      = cur_reg;
        lw_valid_next = lw_valid_reg;
        lw_addr_next  = lw_addr_reg;
        lw_data_next  = lw_data_reg;
        pf_valid_next = pf_valid_reg;
        pf_addr_next  = pf_addr_reg;
        pf_data_next  = pf_data_reg;
        hit_pf        = 1'b0;
        hit_lw        = 1'b0;
        start_pref    = 1'b0;
`endif

        // Lane sequencing is the same for demand and prefetch accesses.
        // The address stays put for WAIT cycles, then the byte is captured.
        if (busy) begin
            if (cap_now) begin
                asm_next = word_cap;
                if (!last_cap) begin
                    lane_next    = lane_reg + LANE_W'(1);
                    fl_addr_next = fl_addr_reg + FL_ADDR_W'(1);
                    cnt_next     = CNT_LOAD;
                end
            end else begin
                cnt_next = cnt_reg - CNT_W'(1);
            end
        end

        case (state_reg)
            S_IDLE: begin
                if (bus.req) begin
`ifdef FETCH_PREFETCH_EN
                    if (pf_hit)      hit_pf    = 1'b1;
                    else if (lw_hit) hit_lw    = 1'b1;
                    else             start_req = 1'b1;
`else
                    start_req = 1'b1;
`endif
                end
            end
            S_FETCH: begin
                if (last_cap) demand_done = 1'b1;
            end
            S_DONE: begin
                if (!bus.req) begin
                    rdy_next = 1'b0;
`ifdef FETCH_PREFETCH_EN
                    if (pf_valid_reg && (pf_addr_reg == pref_addr)) state_next = S_IDLE;
                    else                                            start_pref = 1'b1;
`else
                    state_next = S_IDLE;
`endif
                end
            end
`ifdef FETCH_PREFETCH_EN
            S_PREF: begin
                if (bus.req) begin
                    if (bus.addr == cur_reg) begin
                        // The CPU wants the word in flight: keep the access
                        // going and hand it over as a demand fetch.
                        if (last_cap) demand_done = 1'b1;
                        else          state_next  = S_FETCH;
                    end
                    else if (pf_hit) hit_pf    = 1'b1;
                    else if (lw_hit) hit_lw    = 1'b1;
                    else             start_req = 1'b1;
                end else if (last_cap) begin
                    pf_valid_next = 1'b1;
                    pf_addr_next  = cur_reg;
                    pf_data_next  = word_cap;
                    state_next    = S_IDLE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase

        // The word is returned even if req was dropped during the fetch.
        // rdy is only raised when the CPU is still waiting for it.
        if (demand_done) begin
            data_next = word_cap;
            if (bus.req) begin
                rdy_next   = 1'b1;
                state_next = S_DONE;
            end else begin
                state_next = S_IDLE;
            end
`ifdef FETCH_PREFETCH_EN
            lw_valid_next = 1'b1;
            lw_addr_next  = cur_reg;
            lw_data_next  = word_cap;
`endif
        end

        if (start_req) begin
            state_next   = S_FETCH;
            fl_addr_next = lane0_addr(bus.addr);
            cnt_next     = CNT_LOAD;
            lane_next    = '0;
`ifdef FETCH_PREFETCH_EN
            cur_next     = bus.addr;
`endif
        end

`ifdef FETCH_PREFETCH_EN
        if (hit_pf) begin
            // The prefetched word becomes the last word. Leaving DONE then
            // starts the next sequential prefetch.
            data_next     = pf_data_reg;
            rdy_next      = 1'b1;
            state_next    = S_DONE;
            cur_next      = bus.addr;
            lw_valid_next = 1'b1;
            lw_addr_next  = pf_addr_reg;
            lw_data_next  = pf_data_reg;
            pf_valid_next = 1'b0;
        end else if (hit_lw) begin
            data_next  = lw_data_reg;
            rdy_next   = 1'b1;
            state_next = S_DONE;
            cur_next   = bus.addr;
        end

        if (start_pref) begin
            state_next   = S_PREF;
            cur_next     = pref_addr;
            fl_addr_next = lane0_addr(pref_addr);
            cnt_next     = CNT_LOAD;
            lane_next    = '0;
        end
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            lane_reg    <= '0;
            cnt_reg     <= '0;
            fl_addr_reg <= '0;
            asm_reg     <= '0;
            data_reg    <= '0;
            rdy_reg     <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            cur_reg      <= '0;
            lw_valid_reg <= 1'b0;
            lw_addr_reg  <= '0;
            lw_data_reg  <= '0;
            pf_valid_reg <= 1'b0;
            pf_addr_reg  <= '0;
            pf_data_reg  <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            lane_reg    <= lane_next;
            cnt_reg     <= cnt_next;
            fl_addr_reg <= fl_addr_next;
            asm_reg     <= asm_next;
            data_reg    <= data_next;
            rdy_reg     <= rdy_next;
`ifdef FETCH_PREFETCH_EN
            cur_reg      <= cur_next;
            lw_valid_reg <= lw_valid_next;
            lw_addr_reg  <= lw_addr_next;
            lw_data_reg  <= lw_data_next;
            pf_valid_reg <= pf_valid_next;
            pf_addr_reg  <= pf_addr_next;
            pf_data_reg  <= pf_data_next;
`endif
        end
    end

    assign bus.rdy  = rdy_reg;
    assign bus.data = data_reg;
    assign fl_addr  = fl_addr_reg;
    assign fl_ce_n  = ~busy;
    assign fl_oe_n  = ~busy;
endmodule

// File: tb/tb_flash_word_fetch.sv
module tb_flash_word_fetch;
    localparam int          BYTES = 2;
    localparam int          WAIT  = 4;
    localparam int          LAT   = BYTES * WAIT;
    localparam logic [21:0] BASE1 = 22'h000000;
    localparam logic [21:0] BASE2 = 22'h3FFFFE;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        busy, fl_ce_n, fl_oe_n;
    logic [21:0] fl_addr;
    logic [7:0]  fl_dq;
    logic        busy2, fl_ce_n2, fl_oe_n2;
    logic [21:0] fl_addr2;
    logic [7:0]  fl_dq2;

    int checks   = 0;
    int failures = 0;
    logic [21:0] trace [16];

    always #10 clk = ~clk;

    flash_word_fetch_if #(.ADDR_W(16), .DATA_W(8*BYTES)) bus ();
    flash_word_fetch_if #(.ADDR_W(16), .DATA_W(8*BYTES)) bus2 ();

    flash_word_fetch #(.ADDR_W(16), .BYTES(BYTES), .WAIT(WAIT), .FL_ADDR_W(22), .BASE(BASE1)) dut (
        .CLOCK_50(clk), .reset_n(reset_n), .bus(bus), .busy(busy),
        .fl_addr(fl_addr), .fl_dq(fl_dq), .fl_ce_n(fl_ce_n), .fl_oe_n(fl_oe_n));

    flash_word_fetch #(.ADDR_W(16), .BYTES(BYTES), .WAIT(WAIT), .FL_ADDR_W(22), .BASE(BASE2)) dut2 (
        .CLOCK_50(clk), .reset_n(reset_n), .bus(bus2), .busy(busy2),
        .fl_addr(fl_addr2), .fl_dq(fl_dq2), .fl_ce_n(fl_ce_n2), .fl_oe_n(fl_oe_n2));

    // Flash contents: fixed test bytes plus an address-derived pattern.
    function automatic logic [7:0] fb(input logic [21:0] a);
        if (a == 22'h000246) return 8'hA5;
        if (a == 22'h000247) return 8'h3C;
        return a[7:0] ^ {a[13:8], 2'b00} ^ {2'b00, a[21:16]} ^ 8'h5A;
    endfunction

    function automatic logic [21:0] lane_of(input logic [15:0] a, input logic [21:0] base);
        return base + 22'(a) * 22'(BYTES);
    endfunction

    function automatic logic [8*BYTES-1:0] word_of(input logic [15:0] a, input logic [21:0] base);
        logic [8*BYTES-1:0] w;
        for (int j = 0; j < BYTES; j++) w[8*j +: 8] = fb(lane_of(a, base) + 22'(j));
        return w;
    endfunction

    assign fl_dq  = fb(fl_addr);
    assign fl_dq2 = fb(fl_addr2);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a request on the main DUT (called at a negedge). lat is the number
    // of edges after the sampling edge at which rdy appears. trace[i] is
    // fl_addr after sampling edge + i.
    task automatic do_req(input logic [15:0] a, input int hold, output int lat);
        logic [8*BYTES-1:0] exp;
        exp = word_of(a, BASE1);
        bus.req  = 1'b1;
        bus.addr = a;
        lat = -1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (i < 16) trace[i] = fl_addr;
            if (bus.rdy === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) chk("rdy_timeout", 64'(lat), 64'(LAT));
        chk("req_data", 64'(bus.data), 64'(exp));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_rdy", 64'(bus.rdy), 64'd1);
            chk("hold_data", 64'(bus.data), 64'(exp));
            chk("hold_oe_n", 64'(fl_oe_n), 64'd1);
        end
        bus.req = 1'b0;
        tick();
        chk("drop_rdy", 64'(bus.rdy), 64'd0);
        $display("txn addr=%h lat=%0d data=%h exp=%h hold=%0d", a, lat, bus.data, exp, hold);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        bus.req  = 1'b0;
        bus2.req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

`ifndef FETCH_PREFETCH_EN
    // Elapsed-time model: after an accepted request, lane n is on the bus for
    // WAIT cycles each, and the word appears after BYTES*WAIT edges.
    int                 m_phase = 0;
    int                 m_el    = 0;
    bit                 m_live  = 1'b0;
    logic [21:0]        m_l0, m_fl;
    logic [8*BYTES-1:0] m_word, m_data;
    logic               m_rdy, m_busy;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_live = 1'b1; m_phase = 0; m_rdy = 1'b0; m_busy = 1'b0;
            m_data = '0; m_fl = '0;
        end else if (m_live) begin
            case (m_phase)
                0: if (bus.req) begin
                    m_phase = 1; m_el = 0;
                    m_l0 = lane_of(bus.addr, BASE1);
                    m_word = word_of(bus.addr, BASE1);
                    m_fl = m_l0; m_busy = 1'b1;
                end
                1: begin
                    m_el++;
                    if (m_el == LAT) begin
                        m_busy = 1'b0; m_data = m_word;
                        if (bus.req) begin m_rdy = 1'b1; m_phase = 2; end
                        else m_phase = 0;
                    end else begin
                        m_fl = m_l0 + 22'(m_el / WAIT);
                    end
                end
                default: if (!bus.req) begin m_rdy = 1'b0; m_phase = 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc_busy", 64'(busy), 64'(m_busy));
            chk("cyc_ce_n", 64'(fl_ce_n), 64'(!m_busy));
            chk("cyc_oe_n", 64'(fl_oe_n), 64'(!m_busy));
            chk("cyc_fl_addr", 64'(fl_addr), 64'(m_fl));
            chk("cyc_rdy", 64'(bus.rdy), 64'(m_rdy));
            if (m_phase != 1) chk("cyc_data", 64'(bus.data), 64'(m_data));
        end
    end
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int exp_hit;
`ifdef FETCH_PREFETCH_EN
        exp_hit = 0;
`else
        exp_hit = LAT;
`endif
        reset_n = 1'b0;
        bus.req = 1'b0;  bus.addr = '0;
        bus2.req = 1'b0; bus2.addr = '0;
        tick();
        tick();
        chk("rst_rdy", 64'(bus.rdy), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(bus.data), 64'd0);
        chk("rst_fl_addr", 64'(fl_addr), 64'd0);
        chk("rst_ce_n", 64'(fl_ce_n), 64'd1);
        chk("rst_oe_n", 64'(fl_oe_n), 64'd1);
        reset_n = 1'b1;
        tick();

        // Known word: lanes at 0x0246/0x0247, 4 cycles each.
        do_req(16'h0123, 5, lat);
        chk("t0123_lat", 64'(lat), 64'(LAT));
        for (int i = 0; i < 4; i++) chk("t0123_lane0", 64'(trace[i]), 64'h0246);
        for (int i = 4; i < 8; i++) chk("t0123_lane1", 64'(trace[i]), 64'h0247);
        chk("t0123_data", 64'(word_of(16'h0123, BASE1)), 64'h3CA5);

        // Address wrap with BASE close to the top of the flash.
        bus2.req = 1'b1;
        bus2.addr = 16'hFFFF;
        lat = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            trace[i] = fl_addr2;
            if (bus2.rdy === 1'b1) begin lat = i; break; end
        end
        chk("wrap_lat", 64'(lat), 64'(LAT));
        chk("wrap_lane0", 64'(trace[0]), 64'h01FFFC);
        chk("wrap_lane0_end", 64'(trace[3]), 64'h01FFFC);
        chk("wrap_lane1", 64'(trace[4]), 64'h01FFFD);
        chk("wrap_data", 64'(bus2.data), 64'({fb(22'h01FFFD), fb(22'h01FFFC)}));
        bus2.req = 1'b0;
        tick();
        chk("wrap_drop_rdy", 64'(bus2.rdy), 64'd0);
        $display("txn wrap addr=ffff lat=%0d data=%h", lat, bus2.data);

        // Reset in the middle of lane 1.
        bus.req = 1'b1;
        bus.addr = 16'h0200;
        repeat (6) tick();
        chk("mid_lane1_addr", 64'(fl_addr), 64'h0401);
        reset_n = 1'b0;
        bus.req = 1'b0;
        tick();
        chk("midrst_rdy", 64'(bus.rdy), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_data", 64'(bus.data), 64'd0);
        chk("midrst_oe_n", 64'(fl_oe_n), 64'd1);
        chk("midrst_fl_addr", 64'(fl_addr), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        $display("txn midreset addr=0200 done");

        // Random traffic, some requests dropped while the fetch is running.
        for (int t = 0; t < 40; t++) begin
            logic [15:0] a;
            a = 16'($urandom) | 16'h8000;
            if ($urandom_range(0, 3) == 0) begin
                int d;
                d = $urandom_range(1, LAT - 2);
                bus.req = 1'b1;
                bus.addr = a;
                repeat (d) tick();
                bus.req = 1'b0;
                repeat (LAT + 2) tick();
                chk("abort_rdy", 64'(bus.rdy), 64'd0);
                $display("txn abort addr=%h after=%0d data=%h", a, d, bus.data);
            end else begin
                do_req(a, $urandom_range(0, 3), lat);
`ifndef FETCH_PREFETCH_EN
                chk("rand_lat", 64'(lat), 64'(LAT));
`endif
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        // Sequential access pattern. With prefetch the buffer answers at once.
        do_reset();
        do_req(16'h0010, 0, lat);
        chk("seq10_lat", 64'(lat), 64'(LAT));
        repeat (10) tick();
        do_req(16'h0011, 0, lat);
        chk("seq11_lat", 64'(lat), 64'(exp_hit));
        do_req(16'h0011, 0, lat);
        chk("seq11_again_lat", 64'(lat), 64'(exp_hit));
        tick();
        do_req(16'h0040, 0, lat);
        chk("abort40_first_addr", 64'(trace[0]), 64'h0080);
        chk("abort40_lat", 64'(lat), 64'(LAT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
